// File: rtl/axis_pkt_arbiter_if.sv
// AXI4-Stream channel bundle shared by the arbiter inputs and output.
// master drives the payload and TVALID; slave drives TREADY.
interface axis_pkt_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int USER_W = 32,
    parameter int STRB_W = 4
);
    logic [DATA_W-1:0] TDATA;
    logic [STRB_W-1:0] TSTRB;
    logic [USER_W-1:0] TUSER;
    logic              TLAST;
    logic              TVALID;
    logic              TREADY;

    modport master (
        output TDATA,
        output TSTRB,
        output TUSER,
        output TLAST,
        output TVALID,
        input  TREADY
    );

    modport slave (
        input  TDATA,
        input  TSTRB,
        input  TUSER,
        input  TLAST,
        input  TVALID,
        output TREADY
    );
endinterface

// File: rtl/axis_pkt_arbiter.sv
// Two-input packet-granular round-robin AXIS arbiter with a registered
// one-entry output stage and per-input packet counters.
module axis_pkt_arbiter #(
    parameter int DATA_W = 32,
    parameter int USER_W = 32,
    parameter int STRB_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic             ARB_EN,
    axis_pkt_arbiter_if.slave  s0_axis,
    axis_pkt_arbiter_if.slave  s1_axis,
    axis_pkt_arbiter_if.master m_axis,
    output logic [1:0]       GRANT,
    output logic [CNT_W-1:0] PKT_CNT0,
    output logic [CNT_W-1:0] PKT_CNT1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              rr_q, rr_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;

    logic              ovalid_q, ovalid_d;
    logic [DATA_W-1:0] odata_q, odata_d;
    logic [STRB_W-1:0] ostrb_q, ostrb_d;
    logic [USER_W-1:0] ouser_q, ouser_d;
    logic              olast_q, olast_d;

    logic              stage_rdy;
    logic              acc0;
    logic              acc1;

    // The output register can take a beat if empty or draining this cycle.
    assign stage_rdy = !ovalid_q || m_axis.TREADY;

    assign s0_axis.TREADY = (state_q == OWN0) && stage_rdy;
    assign s1_axis.TREADY = (state_q == OWN1) && stage_rdy;

    assign acc0 = s0_axis.TVALID && s0_axis.TREADY;
    assign acc1 = s1_axis.TVALID && s1_axis.TREADY;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        unique case (state_q)
            IDLE: begin
                if (ARB_EN) begin
                    if (s0_axis.TVALID && s1_axis.TVALID) begin
                        state_d = rr_q ? OWN1 : OWN0;
                    end else if (s0_axis.TVALID) begin
                        state_d = OWN0;
                    end else if (s1_axis.TVALID) begin
                        state_d = OWN1;
                    end
                end
            end
            OWN0: begin
                if (acc0 && s0_axis.TLAST) begin
                    state_d = IDLE;
                    rr_d    = 1'b1;
                    cnt0_d  = cnt0_q + CNT_W'(1);
                end
            end
            OWN1: begin
                if (acc1 && s1_axis.TLAST) begin
                    state_d = IDLE;
                    rr_d    = 1'b0;
                    cnt1_d  = cnt1_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Loading a new beat wins over draining, so accept+drain keeps valid.
    always_comb begin
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        ostrb_d  = ostrb_q;
        ouser_d  = ouser_q;
        olast_d  = olast_q;
        if (acc0) begin
            ovalid_d = 1'b1;
            odata_d  = s0_axis.TDATA;
            ostrb_d  = s0_axis.TSTRB;
            ouser_d  = s0_axis.TUSER;
            olast_d  = s0_axis.TLAST;
        end else if (acc1) begin
            ovalid_d = 1'b1;
            odata_d  = s1_axis.TDATA;
            ostrb_d  = s1_axis.TSTRB;
            ouser_d  = s1_axis.TUSER;
            olast_d  = s1_axis.TLAST;
        end else if (m_axis.TREADY) begin
            ovalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            ostrb_q  <= '0;
            ouser_q  <= '0;
            olast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            ostrb_q  <= ostrb_d;
            ouser_q  <= ouser_d;
            olast_q  <= olast_d;
        end
    end

    assign m_axis.TVALID = ovalid_q;
    assign m_axis.TDATA  = odata_q;
    assign m_axis.TSTRB  = ostrb_q;
    assign m_axis.TUSER  = ouser_q;
    assign m_axis.TLAST  = olast_q;

    assign GRANT    = {state_q == OWN1, state_q == OWN0};
    assign PKT_CNT0 = cnt0_q;
    assign PKT_CNT1 = cnt1_q;

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Bench for axis_pkt_arbiter: queue-based transaction model checked every
// cycle, plus directed literal expectations for each scenario.
module tb_axis_pkt_arbiter;

    localparam int DW = 32;
    localparam int UW = 32;
    localparam int SW = 4;
    // Narrow counters keep the wrap scenario short.
    localparam int CW = 8;

    typedef struct {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic clk;
    logic rst;
    logic en;
    logic [1:0]    grant;
    logic [CW-1:0] cnt0;
    logic [CW-1:0] cnt1;

    axis_pkt_arbiter_if #(.DATA_W(DW), .USER_W(UW), .STRB_W(SW)) s0_if ();
    axis_pkt_arbiter_if #(.DATA_W(DW), .USER_W(UW), .STRB_W(SW)) s1_if ();
    axis_pkt_arbiter_if #(.DATA_W(DW), .USER_W(UW), .STRB_W(SW)) m_if ();

    axis_pkt_arbiter #(
        .DATA_W(DW), .USER_W(UW), .STRB_W(SW), .CNT_W(CW)
    ) dut (
        .ACLK    (clk),
        .ARESET  (rst),
        .ARB_EN  (en),
        .s0_axis (s0_if),
        .s1_axis (s1_if),
        .m_axis  (m_if),
        .GRANT   (grant),
        .PKT_CNT0(cnt0),
        .PKT_CNT1(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- producers and sink ready ----------------
    beat_t src0[$];
    beat_t src1[$];
    int    fires0 = 0;
    int    fires1 = 0;
    int    bp_mode = 0;
    int    bp_i = 0;

    task automatic push_pkt(input int k, input logic [DW-1:0] base,
                            input int n, input logic [UW-1:0] user);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.d = base + DW'(i);
            b.s = (i == n - 1) ? 4'h3 : 4'hF;
            b.u = user;
            b.l = (i == n - 1);
            if (k == 0) src0.push_back(b);
            else src1.push_back(b);
        end
    endtask

    task automatic present();
        s0_if.TVALID = (src0.size() != 0);
        s1_if.TVALID = (src1.size() != 0);
        if (src0.size() != 0) begin
            s0_if.TDATA = src0[0].d; s0_if.TSTRB = src0[0].s;
            s0_if.TUSER = src0[0].u; s0_if.TLAST = src0[0].l;
        end else begin
            s0_if.TDATA = '0; s0_if.TSTRB = '0;
            s0_if.TUSER = '0; s0_if.TLAST = 1'b0;
        end
        if (src1.size() != 0) begin
            s1_if.TDATA = src1[0].d; s1_if.TSTRB = src1[0].s;
            s1_if.TUSER = src1[0].u; s1_if.TLAST = src1[0].l;
        end else begin
            s1_if.TDATA = '0; s1_if.TSTRB = '0;
            s1_if.TUSER = '0; s1_if.TLAST = 1'b0;
        end
    endtask

    initial begin
        bit f0, f1;
        present();
        m_if.TREADY = 1'b1;
        forever begin
            @(negedge clk);
            f0 = s0_if.TVALID && s0_if.TREADY;
            f1 = s1_if.TVALID && s1_if.TREADY;
            @(posedge clk);
            #2;
            if (f0 && src0.size() != 0) begin
                src0.delete(0);
                fires0++;
            end
            if (f1 && src1.size() != 0) begin
                src1.delete(0);
                fires1++;
            end
            present();
            if (bp_mode == 0) begin
                m_if.TREADY = 1'b1;
            end else begin
                m_if.TREADY = (bp_i % 4 == 0) || (bp_i % 4 == 3);
                bp_i++;
            end
        end
    end

    // ---------------- transaction-level model ----------------
    int            own = -1;
    bit            rr = 1'b0;
    logic [CW-1:0] mc0 = '0;
    logic [CW-1:0] mc1 = '0;
    beat_t         oq[$];

    initial begin
        bit v0, v1, mr, room;
        beat_t b;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                own = -1; rr = 1'b0; mc0 = '0; mc1 = '0;
                oq.delete();
            end else begin
                v0 = s0_if.TVALID; v1 = s1_if.TVALID;
                mr = m_if.TREADY;
                room = (oq.size() == 0) || mr;
                if (oq.size() != 0 && mr) oq.delete(0);
                if (own == 0 && v0 && room) begin
                    b.d = s0_if.TDATA; b.s = s0_if.TSTRB;
                    b.u = s0_if.TUSER; b.l = s0_if.TLAST;
                    oq.push_back(b);
                    if (b.l) begin mc0++; rr = 1'b1; own = -1; end
                end else if (own == 1 && v1 && room) begin
                    b.d = s1_if.TDATA; b.s = s1_if.TSTRB;
                    b.u = s1_if.TUSER; b.l = s1_if.TLAST;
                    oq.push_back(b);
                    if (b.l) begin mc1++; rr = 1'b0; own = -1; end
                end else if (own == -1 && en && (v0 || v1)) begin
                    own = (v0 && v1) ? int'(rr) : (v0 ? 0 : 1);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        logic [1:0] eg;
        bit room;
        forever begin
            @(negedge clk);
            eg = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
            room = (oq.size() == 0) || m_if.TREADY;
            chk("grant", 64'(grant), 64'(eg));
            chk("cnt0", 64'(cnt0), 64'(mc0));
            chk("cnt1", 64'(cnt1), 64'(mc1));
            chk("s0_ready", 64'(s0_if.TREADY), 64'(own == 0 && room));
            chk("s1_ready", 64'(s1_if.TREADY), 64'(own == 1 && room));
            chk("m_valid", 64'(m_if.TVALID), 64'(oq.size() != 0));
            if (oq.size() != 0) begin
                chk("m_data", 64'(m_if.TDATA), 64'(oq[0].d));
                chk("m_strb", 64'(m_if.TSTRB), 64'(oq[0].s));
                chk("m_user", 64'(m_if.TUSER), 64'(oq[0].u));
                chk("m_last", 64'(m_if.TLAST), 64'(oq[0].l));
            end
        end
    end

    // ---------------- sequence helpers ----------------
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        while (!(src0.size() == 0 && src1.size() == 0 &&
                 oq.size() == 0 && own == -1) && n < max) begin
            @(negedge clk);
            n++;
        end
        if (n >= max) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles", name, max);
        end
        tick();
    endtask

    task automatic wait_grant(input string name, input int max,
                              input logic [1:0] exp);
        int n = 0;
        @(negedge clk);
        while (grant == 2'b00 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(grant), 64'(exp));
    endtask

    task automatic wait_fires(input int k, input int target, input int max);
        int n = 0;
        while (((k == 0) ? fires0 : fires1) < target && n < max) begin
            tick();
            n++;
        end
        if (n >= max) begin
            errors++;
            $display("FAIL fires%0d: timeout waiting for %0d", k, target);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        rst = 1'b1;
        en  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_mvalid", 64'(m_if.TVALID), 64'h0);
        chk("rst_s0_ready", 64'(s0_if.TREADY), 64'h0);
        tick();
        rst = 1'b0;

        // Both inputs streaming 4-beat packets.
        for (int p = 0; p < 8; p++) begin
            push_pkt(0, 32'hA000_0000 + 32'(p * 4), 4, 32'h0004_0001);
            push_pkt(1, 32'hB000_0000 + 32'(p * 4), 4, 32'h0004_0002);
        end
        wait_grant("t1_first_grant", 20, 2'b01);
        wait_done("t1_done", 400);
        chk("t1_cnt0", 64'(cnt0), 64'd8);
        chk("t1_cnt1", 64'(cnt1), 64'd8);

        // S1 only, opaque TUSER.
        for (int p = 0; p < 4; p++)
            push_pkt(1, 32'hC000_0000 + 32'(p * 3), 3, 32'h000C_0042);
        wait_grant("t2_grant", 20, 2'b10);
        n = 0;
        while (!m_if.TVALID && n < 20) begin @(negedge clk); n++; end
        chk("t2_user", 64'(m_if.TUSER), 64'h000C_0042);
        wait_done("t2_done", 200);
        chk("t2_cnt1", 64'(cnt1), 64'd12);

        // Output backpressure 1,0,0,1 on an 8-beat S0 packet.
        bp_i = 0;
        bp_mode = 1;
        push_pkt(0, 32'hD000_0000, 8, 32'h0008_0003);
        wait_done("t3_done", 200);
        bp_mode = 0;
        chk("t3_cnt0", 64'(cnt0), 64'd9);

        // ARB_EN dropped mid-packet.
        push_pkt(0, 32'hE000_0000, 8, 32'h0008_0004);
        wait_fires(0, fires0 + 3, 50);
        push_pkt(1, 32'hE100_0000, 2, 32'h0002_0005);
        push_pkt(0, 32'hE200_0000, 2, 32'h0002_0006);
        en = 1'b0;
        n = 0;
        while (src0.size() > 2 && n < 50) begin tick(); n++; end
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold_idle", 64'(grant), 64'h0);
        end
        tick();
        en = 1'b1;
        wait_grant("t4_next_grant", 20, 2'b10);
        wait_done("t4_done", 200);
        chk("t4_cnt0", 64'(cnt0), 64'd11);
        chk("t4_cnt1", 64'(cnt1), 64'd13);

        // Reset on beat 2 of a 5-beat S1 packet.
        push_pkt(1, 32'hF000_0000, 5, 32'h0005_0007);
        wait_fires(1, fires1 + 2, 50);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_cnt1", 64'(cnt1), 64'h0);
        chk("t5_mvalid", 64'(m_if.TVALID), 64'h0);
        chk("t5_grant", 64'(grant), 64'h0);
        src0.delete();
        src1.delete();
        tick();
        rst = 1'b0;
        push_pkt(0, 32'h1000_0000, 2, 32'h0002_0008);
        push_pkt(1, 32'h1100_0000, 2, 32'h0002_0009);
        wait_grant("t5_grant_after", 20, 2'b01);
        wait_done("t5_done", 200);

        // Single-beat packets wrap the S0 counter.
        for (int p = 0; p < 253; p++)
            push_pkt(0, 32'h2000_0000 + 32'(p), 1, 32'h0001_000A);
        wait_done("t6_fill", 2000);
        chk("t6_cnt0_fe", 64'(cnt0), 64'hFE);
        push_pkt(0, 32'h3000_0000, 1, 32'h0001_000B);
        push_pkt(0, 32'h3000_0001, 1, 32'h0001_000B);
        wait_done("t6_wrap", 100);
        chk("t6_cnt0_wrap", 64'(cnt0), 64'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_pkt_arbiter.md
Name: axis_pkt_arbiter

Overview:
- Two-input, packet-granular AXI4-Stream arbiter that merges two producer streams into the single stream consumed by the OPED AXIS slave.
- Replaces the direct loopback path on the OPED consume side.
- Grants are round-robin and held for a whole packet, from grant to TLAST.
- Output passes through a one-entry registered stage that sustains full throughput.
- Per-input packet counters are provided for status/debug.

Parameters:
- DATA_W, 32, TDATA width in bits.
- USER_W, 32, TUSER width in bits. [31:16] is the length, [7:0] the opcode; the arbiter passes TUSER through opaquely.
- STRB_W, 4, TSTRB width; equals DATA_W/8.
- CNT_W, 16, width of the per-input packet counters.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- ARB_EN  in  1  1 = new grants allowed; 0 = finish the current packet, then hold IDLE.
- S0_AXIS_TDATA/TSTRB/TUSER/TLAST/TVALID  in  DATA_W/STRB_W/USER_W/1/1  producer 0 stream.
- S0_AXIS_TREADY  out  1  ready to producer 0.
- S1_AXIS_TDATA/TSTRB/TUSER/TLAST/TVALID  in  DATA_W/STRB_W/USER_W/1/1  producer 1 stream.
- S1_AXIS_TREADY  out  1  ready to producer 1.
- M_AXIS_TDATA/TSTRB/TUSER/TLAST/TVALID  out  DATA_W/STRB_W/USER_W/1/1  merged stream to OPED.
- M_AXIS_TREADY  in  1  ready from OPED.
- GRANT  out  2  one-hot current owner; 00 in IDLE.
- PKT_CNT0, PKT_CNT1  out  CNT_W  packets forwarded from each input.

Behaviour:
- Reset (async assert, sync to ACLK on release):
  - state=IDLE, rr_ptr=0 (input 0 has priority first).
  - Output register valid=0; data/strb/user/last registers=0.
  - GRANT=00, PKT_CNTx=0, Sx_AXIS_TREADY=0, M_AXIS_TVALID=0.
- FSM states are IDLE, OWN0 and OWN1.
- IDLE:
  - If ARB_EN=1 and any Sx TVALID=1, pick the owner:
    - only one TVALID asserted: that input;
    - both asserted: input rr_ptr.
  - Move to OWNk at the next edge.
  - No beat is accepted in IDLE, so there is one bubble cycle per packet boundary.
- OWNk:
  - Sk_AXIS_TREADY = (!out_valid | M_AXIS_TREADY).
  - The other input's TREADY is 0.
  - On Sk TVALID&TREADY with TLAST=1:
    - go to IDLE;
    - rr_ptr <= ~k;
    - PKT_CNTk += 1, wrapping at 2^CNT_W.
  - TVALID deassertion mid-packet is legal; ownership is held indefinitely until TLAST.
  - ARB_EN has no effect while in OWNk.
- Output stage:
  - On an accepted input beat, load TDATA/TSTRB/TUSER/TLAST and set out_valid=1.
  - Else, if M_AXIS_TREADY=1, clear out_valid.
  - Accept and drain in the same cycle keeps out_valid=1 with the new data.
  - M_AXIS_* are driven directly from registers.
  - Latency is 1 cycle input-to-output; throughput is 1 beat/cycle within a packet.
- M_AXIS_TVALID, once high, stays high with stable data until M_AXIS_TREADY=1.
- The combinational path M_AXIS_TREADY -> Sx_AXIS_TREADY is permitted.
- No other combinational paths exist from inputs to outputs.
- GRANT reflects the registered state: 01 for OWN0, 10 for OWN1.
- Reset mid-packet:
  - Everything clears immediately, including M_AXIS_TVALID.
  - The partial packet is discarded.
  - Upstream producers are reset by the same ARESET.
- Single-beat packets (TLAST on the first beat) are legal: OWNk lasts 1 cycle, then IDLE.
- Zero-length packets do not exist; every packet has at least one beat.

Test Plan:
1. Both inputs continuously offer 4-beat packets, TDATA 0xA000_0000+n / 0xB000_0000+n, M_AXIS_TREADY=1.
   - Output alternates S0,S1,S0,S1 packets with no interleaving.
   - One idle cycle between packets.
   - PKT_CNT0=PKT_CNT1=8 after 16 packets.
2. Only S1 active with 3-beat packets, TUSER=0x000C_0042.
   - Every packet is granted to S1; TUSER is unchanged at the output.
   - Output beats appear 1 cycle after input acceptance.
3. Backpressure: M_AXIS_TREADY toggles 1,0,0,1 repeating during an 8-beat S0 packet.
   - No beat is lost or duplicated; TDATA is held stable while TVALID=1 and TREADY=0.
   - S0_AXIS_TREADY=0 whenever out_valid=1 and M_AXIS_TREADY=0.
4. ARB_EN drops to 0 in the middle of an S0 packet.
   - The S0 packet completes and the FSM goes to IDLE.
   - While both TVALID are high, GRANT stays 00 until ARB_EN=1.
   - The next grant then goes to S1 (rr_ptr=1).
5. ARESET pulsed on beat 2 of a 5-beat S1 packet.
   - All outputs are 0 within the reset cycle; PKT_CNT1=0.
   - After release, the first grant goes to S0 when both are valid.
6. PKT_CNT0 preloaded to 0xFFFE via 0xFFFE single-beat packets, then 2 more packets.
   - PKT_CNT0 wraps to 0x0000.
   - Each single-beat packet occupies OWN0 for exactly 1 cycle.
